timer_cmd_master: RTL and testbench
===================================

// Module: timer_cmd_master
// PURPOSE
//  Avalon-MM initiator that drives the 16-bit interval-timer slave (regs: 0 status, 1 control, 2/3 period L/H,
//  4/5 snap L/H) from a simple command/response stream. Turns one command into the required register
//  write/read sequence, returns a single response, and counts timer_irq rising edges.
//  Sits between a control FSM / CPU-less datapath and the timer's s1 port in the Mega_JSoC fabric.
// PARAMETERS
//  ADDR_W        3   Avalon word-address width
//  DATA_W        16  Avalon data width (fixed 16 for this timer map)
//  READ_LATENCY  1   cycles from read-address cycle to valid avm_readdata (1..3)
// PORTS
//  clk             in   1       system clock
//  reset           in   1       synchronous, active-high reset
//  cmd_valid       in   1       command present
//  cmd_ready       out  1       block can accept command
//  cmd_op          in   3       0 LOAD,1 START,2 STOP,3 SNAP,4 STATUS,5 CLEAR; 6,7 illegal
//  cmd_data        in   32      LOAD: period; START/STOP: [1]=CONT,[0]=ITO; else ignored
//  rsp_valid       out  1       response present, held until rsp_ready
//  rsp_ready       in   1       response consumer ready
//  rsp_data        out  32      SNAP: snapshot; STATUS: {30'b0,RUN,TO}; others 0
//  rsp_err         out  1       1 = illegal opcode
//  avm_address     out  ADDR_W  register word address
//  avm_chipselect  out  1       transfer active
//  avm_write_n     out  1       0 = write beat
//  avm_read        out  1       1 = read beat
//  avm_writedata   out  DATA_W  write data
//  avm_readdata    in   DATA_W  read data
//  avm_waitrequest in   1       slave stall (tie 0 for timer)
//  timer_irq       in   1       timer interrupt level
//  irq_count       out  16      saturating count of timer_irq rising edges
// BEHAVIOUR
//  Reset: cmd_ready=0 in reset cycle, 1 after; rsp_valid=0, rsp_data=0, rsp_err=0; avm_chipselect=0,
//   avm_write_n=1, avm_read=0, address/writedata=0; irq_count=0. Reset mid-sequence aborts: bus idle next
//   cycle, command dropped, no response.
//  FSM: IDLE -> BEAT (write or read address) -> [RD_WAIT x READ_LATENCY] -> next BEAT ... -> RESP -> IDLE.
//  cmd accepted on cmd_valid&cmd_ready (ready only in IDLE); cmd_op/cmd_data latched at accept.
//  Beat sequences: LOAD: wr2=data[15:0], wr3=data[31:16]. START: wr1={12'b0,4'b0100|data[1:0]}.
//   STOP: wr1={12'b0,4'b1000|data[1:0]}. SNAP: wr4=0, rd4, rd5. STATUS: rd0. CLEAR: wr0=0.
//  Beat holds address/data/strobes while avm_waitrequest=1; advances on first cycle with waitrequest=0.
//  Read: address cycle, then avm_read deasserted and chipselect low; avm_readdata sampled exactly
//   READ_LATENCY cycles after the accepted address cycle. rd4 -> rsp_data[15:0], rd5 -> rsp_data[31:16].
//  Between beats bus returns idle for 0 cycles (back-to-back writes allowed).
//  Latency (waitrequest=0, READ_LATENCY=1): accept at edge E0; LOAD rsp_valid from cycle E0+3; START/STOP/
//   CLEAR E0+2; STATUS E0+3; SNAP E0+6.
//  Illegal op: no bus traffic, RESP next cycle with rsp_err=1, rsp_data=0.
//  RESP: rsp_valid held, data stable until rsp_ready; IDLE next cycle; cmd_ready rises that cycle.
//  irq_count: +1 on timer_irq 0->1 (registered edge detect), saturates 0xFFFF; CLEAR command also zeroes
//   it on its write beat; if edge and clear coincide, clear wins.
// STRUCTURE
//  Package timer_regs_pkg: register address constants (STATUS..SNAP_H), control bit positions
//   (ITO,CONT,START,STOP), opcode enum, FSM state enum.
//  One sub-module: timer_irq_counter (edge detect + saturating counter + clear).
// TESTING
//  LOAD 0x0001_2345 -> wr addr2 0x2345, wr addr3 0x0001 in consecutive cycles, rsp_valid E0+3, rsp_data 0.
//  START data=3 -> single wr addr1 0x0007; STOP data=0 -> wr addr1 0x0008; rsp_err=0.
//  SNAP with slave model returning 0xBEEF@4, 0x00A5@5, READ_LATENCY=2 -> rsp_data 0x00A5_BEEF.
//  waitrequest held 3 cycles on wr3 of LOAD -> address/writedata stable 4 cycles, rsp delayed by 3.
//  op=7 -> no chipselect, rsp_err=1; rsp_ready low 5 cycles -> rsp held, cmd_ready 0 throughout.
//  3 timer_irq pulses -> irq_count 3; CLEAR coincident with 4th edge -> 0; reset mid-SNAP -> bus idle, no rsp.

Source files
------------

// File: rtl/timer_regs_pkg.sv
// Register map, control bits, opcodes and beat sequencing for the interval-timer command master.
package timer_regs_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    typedef enum logic [2:0] {
        OP_LOAD   = 3'd0,
        OP_START  = 3'd1,
        OP_STOP   = 3'd2,
        OP_SNAP   = 3'd3,
        OP_STATUS = 3'd4,
        OP_CLEAR  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT,
        S_RD_WAIT,
        S_RESP
    } state_e;

    typedef struct packed {
        logic        rd;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        last;
    } beat_t;

    function automatic logic is_legal(input logic [2:0] op);
        return op <= 3'(OP_CLEAR);
    endfunction

    // One entry per bus beat of each command; idx steps through the sequence.
    function automatic beat_t beat_for(input logic [2:0] op, input logic [1:0] idx,
                                       input logic [31:0] data);
        beat_t       b;
        logic [15:0] mode;
        b    = '0;
        mode = {14'b0, data[CTRL_CONT], data[CTRL_ITO]};
        case (op_e'(op))
            OP_LOAD: begin
                b.addr  = idx[0] ? REG_PERIOD_H : REG_PERIOD_L;
                b.wdata = idx[0] ? data[31:16] : data[15:0];
                b.last  = idx[0];
            end
            OP_START: begin
                b.addr  = REG_CONTROL;
                b.wdata = mode | (16'd1 << CTRL_START);
                b.last  = 1'b1;
            end
            OP_STOP: begin
                b.addr  = REG_CONTROL;
                b.wdata = mode | (16'd1 << CTRL_STOP);
                b.last  = 1'b1;
            end
            OP_SNAP: begin
                case (idx)
                    2'd0: b.addr = REG_SNAP_L;
                    2'd1: begin
                        b.rd   = 1'b1;
                        b.addr = REG_SNAP_L;
                    end
                    default: begin
                        b.rd   = 1'b1;
                        b.addr = REG_SNAP_H;
                        b.last = 1'b1;
                    end
                endcase
            end
            OP_STATUS: begin
                b.rd   = 1'b1;
                b.addr = REG_STATUS;
                b.last = 1'b1;
            end
            OP_CLEAR: begin
                b.addr = REG_STATUS;
                b.last = 1'b1;
            end
            default: b.last = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/timer_irq_counter.sv
// Counts rising edges of the timer interrupt level, saturating at all-ones; clear has priority.
module timer_irq_counter
    import timer_regs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        clear,
    output logic [15:0] count
);

    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
            count <= '0;
        end else begin
            irq_q <= irq;
            if (clear) begin
                count <= '0;
            end else if (irq && !irq_q && (count != '1)) begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/timer_cmd_master.sv
// Avalon-MM initiator turning one timer command into its register write/read sequence and one response.
module timer_cmd_master
    import timer_regs_pkg::*;
#(
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [31:0]       cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              timer_irq,
    output logic [15:0]       irq_count
);

    localparam logic [1:0] RL_LAST = 2'(READ_LATENCY - 1);

    state_e      state, state_n;
    logic [2:0]  op_q;
    logic [31:0] data_q;
    logic [1:0]  idx;
    logic [1:0]  wait_cnt;
    beat_t       beat;
    logic        accept;
    logic        write_done;
    logic        capture;
    logic        clear_irq;

    assign beat      = beat_for(op_q, idx, data_q);
    assign clear_irq = write_done && (op_q == 3'(OP_CLEAR));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n        = state;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_read       = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        accept         = 1'b0;
        write_done     = 1'b0;
        capture        = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid && !reset) begin
                    accept  = 1'b1;
                    state_n = is_legal(cmd_op) ? S_BEAT : S_RESP;
                end
            end
            S_BEAT: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_W'(beat.addr);
                if (beat.rd) begin
                    avm_read = 1'b1;
                end else begin
                    avm_write_n   = 1'b0;
                    avm_writedata = DATA_W'(beat.wdata);
                end
                if (!avm_waitrequest) begin
                    if (beat.rd) begin
                        state_n = S_RD_WAIT;
                    end else begin
                        write_done = 1'b1;
                        state_n    = beat.last ? S_RESP : S_BEAT;
                    end
                end
            end
            S_RD_WAIT: begin
                // Bus stays idle; readdata is valid only in the last wait cycle.
                if (wait_cnt == RL_LAST) begin
                    capture = 1'b1;
                    state_n = beat.last ? S_RESP : S_BEAT;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            data_q   <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= cmd_op;
                data_q   <= cmd_data;
                idx      <= '0;
                rsp_data <= '0;
                rsp_err  <= !is_legal(cmd_op);
            end
            if (write_done || capture) idx <= idx + 2'd1;
            wait_cnt <= (state == S_RD_WAIT) ? wait_cnt + 2'd1 : 2'd0;
            if (capture) begin
                case (beat.addr)
                    REG_STATUS: rsp_data        <= {30'b0, avm_readdata[1:0]};
                    REG_SNAP_L: rsp_data[15:0]  <= avm_readdata[15:0];
                    REG_SNAP_H: rsp_data[31:16] <= avm_readdata[15:0];
                    default:    ;
                endcase
            end
        end
    end

    timer_irq_counter u_irq_counter (
        .clk   (clk),
        .reset (reset),
        .irq   (timer_irq),
        .clear (clear_irq),
        .count (irq_count)
    );

endmodule

// File: tb/tb_timer_cmd_master.sv
// Directed bench for timer_cmd_master with a small timer-slave model (read latency 2, optional stalls).
module tb_timer_cmd_master;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic        avm_read;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        avm_waitrequest;
    logic        timer_irq;
    logic [15:0] irq_count;

    always #5 clk = ~clk;

    timer_cmd_master #(
        .ADDR_W       (3),
        .DATA_W       (16),
        .READ_LATENCY (RL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .timer_irq       (timer_irq),
        .irq_count       (irq_count)
    );

    // Slave model: fixed register contents, RL-cycle read pipeline, 0xDEAD outside the valid cycle.
    logic [15:0] sregs [8];
    logic [3:0]  rd_v_p = '0;
    logic [2:0]  rd_a_p [4];
    int unsigned stall_used = 0;
    int unsigned stall_target = 0;
    logic [2:0]  stall_addr = 3'd3;

    assign avm_waitrequest = (stall_used != stall_target) && avm_chipselect && (avm_address == stall_addr);
    assign avm_readdata    = rd_v_p[RL-1] ? sregs[rd_a_p[RL-1]] : 16'hDEAD;

    always @(posedge clk) begin
        if (avm_waitrequest) stall_used <= stall_used + 1;
        rd_v_p    <= {rd_v_p[2:0], avm_chipselect && avm_read && !avm_waitrequest};
        rd_a_p[0] <= avm_address;
        for (int i = 1; i < 4; i++) rd_a_p[i] <= rd_a_p[i-1];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_send", cmd_ready, 1);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
    endtask

    int          lat, ncs, nwr, n_a3;
    logic [2:0]  w_addr [4];
    logic [15:0] w_data [4];
    logic [31:0] r_data;
    logic        r_err;
    bit          got;

    // Counts cycles from accept (first negedge after E0 is cycle E0+1) until rsp_valid is seen.
    task automatic wait_rsp(input int max_cyc, input bit consume);
        lat = 0; ncs = 0; nwr = 0; n_a3 = 0; got = 0;
        r_data = '0; r_err = 1'b0;
        while (!got && lat < max_cyc) begin
            @(negedge clk);
            lat++;
            if (avm_chipselect) ncs++;
            if (avm_chipselect && avm_address == 3'd3 && avm_writedata == 16'h0001) n_a3++;
            if (avm_chipselect && !avm_write_n && !avm_waitrequest) begin
                if (nwr < 4) begin
                    w_addr[nwr] = avm_address;
                    w_data[nwr] = avm_writedata;
                end
                nwr++;
            end
            if (rsp_valid) begin
                got    = 1;
                r_data = rsp_data;
                r_err  = rsp_err;
            end
        end
        chk("rsp_seen", got, 1);
        if (got && consume) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          ncs;
        int          nwr;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic [2:0]  a1;
        logic [15:0] d1;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        sregs[0] = 16'hFFF6; sregs[1] = 16'h1111; sregs[2] = 16'h2222; sregs[3] = 16'h3333;
        sregs[4] = 16'hBEEF; sregs[5] = 16'h00A5; sregs[6] = 16'h6666; sregs[7] = 16'h7777;

        //          op    data          lat rdata         err ncs nwr a0    d0        a1    d1
        vecs[0]  = '{3'd0, 32'h0001_2345, 3, 32'h0,        0, 2,  2,  3'd2, 16'h2345, 3'd3, 16'h0001};
        vecs[1]  = '{3'd1, 32'h0000_0003, 2, 32'h0,        0, 1,  1,  3'd1, 16'h0007, 3'd0, 16'h0000};
        vecs[2]  = '{3'd2, 32'h0000_0000, 2, 32'h0,        0, 1,  1,  3'd1, 16'h0008, 3'd0, 16'h0000};
        vecs[3]  = '{3'd4, 32'h0000_0000, 4, 32'h2,        0, 1,  0,  3'd0, 16'h0000, 3'd0, 16'h0000};
        vecs[4]  = '{3'd3, 32'h0000_0000, 8, 32'h00A5BEEF, 0, 3,  1,  3'd4, 16'h0000, 3'd0, 16'h0000};
        vecs[5]  = '{3'd5, 32'h0000_0000, 2, 32'h0,        0, 1,  1,  3'd0, 16'h0000, 3'd0, 16'h0000};
        vecs[6]  = '{3'd6, 32'h1234_5678, 1, 32'h0,        1, 0,  0,  3'd0, 16'h0000, 3'd0, 16'h0000};
        vecs[7]  = '{3'd0, 32'hFFFF_0000, 3, 32'h0,        0, 2,  2,  3'd2, 16'h0000, 3'd3, 16'hFFFF};
        vecs[8]  = '{3'd1, 32'hFFFF_FFF1, 2, 32'h0,        0, 1,  1,  3'd1, 16'h0005, 3'd0, 16'h0000};
        vecs[9]  = '{3'd2, 32'h0000_0002, 2, 32'h0,        0, 1,  1,  3'd1, 16'h000A, 3'd0, 16'h0000};
        vecs[10] = '{3'd7, 32'h0000_0000, 1, 32'h0,        1, 0,  0,  3'd0, 16'h0000, 3'd0, 16'h0000};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        timer_irq = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_chipselect", avm_chipselect, 0);
        chk("reset_write_n", avm_write_n, 1);
        chk("reset_read", avm_read, 0);
        chk("reset_address", avm_address, 0);
        chk("reset_writedata", avm_writedata, 0);
        chk("reset_irq_count", irq_count, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1);

        for (int v = 0; v < 11; v++) begin
            send_cmd(vecs[v].op, vecs[v].data);
            wait_rsp(30, 1);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            chk($sformatf("v%0d_rsp_data", v), r_data, vecs[v].rdata);
            chk($sformatf("v%0d_rsp_err", v), r_err, vecs[v].err);
            chk($sformatf("v%0d_cs_cycles", v), ncs, vecs[v].ncs);
            chk($sformatf("v%0d_writes", v), nwr, vecs[v].nwr);
            if (vecs[v].nwr >= 1) begin
                chk($sformatf("v%0d_wr0_addr", v), w_addr[0], vecs[v].a0);
                chk($sformatf("v%0d_wr0_data", v), w_data[0], vecs[v].d0);
            end
            if (vecs[v].nwr >= 2) begin
                chk($sformatf("v%0d_wr1_addr", v), w_addr[1], vecs[v].a1);
                chk($sformatf("v%0d_wr1_data", v), w_data[1], vecs[v].d1);
            end
            @(negedge clk);
            chk($sformatf("v%0d_idle_rsp_valid", v), rsp_valid, 0);
            chk($sformatf("v%0d_idle_cmd_ready", v), cmd_ready, 1);
        end

        // Three stall cycles on the period-high write stretch LOAD by three.
        stall_addr   = 3'd3;
        stall_target = stall_used + 3;
        send_cmd(3'd0, 32'h0001_2345);
        wait_rsp(30, 1);
        chk("stall_latency", lat, 6);
        chk("stall_hold_cycles", n_a3, 4);
        chk("stall_writes", nwr, 2);
        chk("stall_wr1_addr", w_addr[1], 3'd3);
        chk("stall_cs_cycles", ncs, 5);

        // Illegal op with response back-pressure.
        rsp_ready = 1'b0;
        send_cmd(3'd7, 32'hFFFF_FFFF);
        wait_rsp(10, 0);
        chk("illegal_latency", lat, 1);
        chk("illegal_err", r_err, 1);
        chk("illegal_cs_cycles", ncs, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("hold%0d_rsp_err", i), rsp_err, 1);
            chk($sformatf("hold%0d_rsp_data", i), rsp_data, 0);
            chk($sformatf("hold%0d_cmd_ready", i), cmd_ready, 0);
            chk($sformatf("hold%0d_chipselect", i), avm_chipselect, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_rsp_valid", rsp_valid, 0);
        chk("hold_release_cmd_ready", cmd_ready, 1);

        // Interrupt edge counting.
        chk("irq_count_start", irq_count, 0);
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #1 timer_irq = 1'b1;
            repeat (2) @(posedge clk);
            #1 timer_irq = 1'b0;
            repeat (2) @(posedge clk);
        end
        @(negedge clk);
        chk("irq_count_3", irq_count, 3);

        // Fourth rising edge lands on the same edge as the CLEAR write beat.
        send_cmd(3'd5, 32'h0);
        timer_irq = 1'b1;
        wait_rsp(10, 1);
        chk("clear_latency", lat, 2);
        @(negedge clk);
        chk("irq_clear_wins", irq_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("irq_level_held_no_count", irq_count, 0);
        #1 timer_irq = 1'b0;
        repeat (2) @(posedge clk);
        #1 timer_irq = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("irq_count_after_clear", irq_count, 1);
        timer_irq = 1'b0;

        // Reset in the middle of a SNAP sequence.
        send_cmd(3'd3, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midreset_cmd_ready_low", cmd_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_chipselect", avm_chipselect, 0);
        chk("midreset_read", avm_read, 0);
        chk("midreset_write_n", avm_write_n, 1);
        chk("midreset_rsp_valid", rsp_valid, 0);
        chk("midreset_irq_count", irq_count, 0);
        chk("midreset_cmd_ready", cmd_ready, 1);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (rsp_valid || avm_chipselect) bad++;
            end
            chk("midreset_no_traffic", bad, 0);
        end

        send_cmd(3'd3, 32'h0);
        wait_rsp(30, 1);
        chk("snap_after_reset_data", r_data, 32'h00A5BEEF);
        chk("snap_after_reset_latency", lat, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
